// File: rtl/mult_4bit_seq.sv
// mult_4bit_seq: sequential 4x4 unsigned shift-add multiplier built around one adder_4bit stage

// adder_4bit: 4-bit ripple-carry adder stage
module adder_4bit (
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  input  logic       carry_in,
  output logic [3:0] out,
  output logic       carry_out
);
  logic [4:0] w_c;
  assign w_c[0] = carry_in;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign out[i]    = in_a[i] ^ in_b[i] ^ w_c[i];
    assign w_c[i+1]  = (in_a[i] & in_b[i]) | (w_c[i] & (in_a[i] ^ in_b[i]));
  end
  assign carry_out = w_c[4];
endmodule

module mult_4bit_seq (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t     r_state, w_next;
  logic [3:0] r_m, r_q, r_a, w_sum;
  logic       r_c, w_cout;
  logic [1:0] r_cnt;
  logic [4:0] w_ca;
  adder_4bit u_add (
    .in_a     (r_a),
    .in_b     (r_m),
    .carry_in (1'b0),
    .out      (w_sum),
    .carry_out(w_cout)
  );
  // r_c is always cleared by the shift, so the no-add path yields {0,A}
  assign w_ca = r_q[0] ? {w_cout, w_sum} : {r_c, r_a};
  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end
  // next-state: accept in IDLE, four CALC steps, one DONE cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? CALC : IDLE;
      CALC:    w_next = (r_cnt == 2'd3) ? DONE : CALC;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // datapath: capture operands, add-then-shift per step, publish product on the last step
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_m     <= '0;
      r_q     <= '0;
      r_a     <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_m   <= in_a;
          r_q   <= in_b;
          r_a   <= '0;
          r_c   <= 1'b0;
          r_cnt <= '0;
          busy  <= 1'b1;
        end
        CALC: begin
          r_a   <= w_ca[4:1];
          r_q   <= {w_ca[0], r_q[3:1]};
          r_c   <= 1'b0;
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            product <= {w_ca[4:1], w_ca[0], r_q[3:1]};
            done    <= 1'b1;
            busy    <= 1'b0;
          end
        end
        DONE:    done <= 1'b0;
        default: done <= 1'b0;
      endcase
    end
  end
endmodule
